// File: rtl/calc_op_sequencer.sv
// -----------------------------------------------------------------------------
// calc_op_sequencer
//   Multi-cycle sequencer between the instruction source and the calculator
//   datapath. Accepts one instruction per valid/ready handshake and decodes it
//   into registered ALU/mux controls. Those controls stay stable from DECODE
//   through WB. A single-cycle MemWrite strobe and a Done pulse are issued at
//   writeback.
//
//   Optional feature macro: CALC_ILLEGAL_TRAP_EN
//     defined     : an illegal opcode jumps from DECODE straight to WB and
//                   pulses o_illegal_op together with o_done.
//     not defined : an illegal opcode runs as a plain ALU op; o_illegal_op
//                   stays 0.
//
// Parameters
//   ALU_LATENCY  cycles spent in EXEC (1..15)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   i_clk                clock, rising edge
//   i_reset              synchronous active-high reset
//   i_instr_valid        instruction valid
//   i_instruction[31:0]  [31:27] opcode, [26:14] RegA, [13:1] RegB, [0] unused
//   o_instr_ready        sequencer idle, can accept an instruction
//   o_alu_opcode[4:0]    registered opcode to the ALU
//   o_reg_a[12:0]        registered operand A
//   o_reg_b[12:0]        registered operand B
//   o_reg_b_mem_mux      operand B from memory output
//   o_reg_a_reg_c_mux    operand A from RegC
//   o_reg_c_mem_out_mux  RegC sourced from memory output
//   o_mem_write          one-cycle memory write strobe
//   o_done               one-cycle retire pulse
//   o_illegal_op         one-cycle illegal-opcode retire pulse
//   o_instr_count        retired-instruction count (wraps)
//
//   state  | meaning
//   IDLE   | ready for an instruction, all controls 0
//   DECODE | controls driven from captured word, wait counter loaded
//   EXEC   | controls held while the ALU result settles
//   WB     | Done (and MemWrite for memory ops) pulse, count updated
// -----------------------------------------------------------------------------
module calc_op_sequencer #(
    parameter int ALU_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_instr_valid,
    input  logic [31:0]      i_instruction,
    output logic             o_instr_ready,
    output logic [4:0]       o_alu_opcode,
    output logic [12:0]      o_reg_a,
    output logic [12:0]      o_reg_b,
    output logic             o_reg_b_mem_mux,
    output logic             o_reg_a_reg_c_mux,
    output logic             o_reg_c_mem_out_mux,
    output logic             o_mem_write,
    output logic             o_done,
    output logic             o_illegal_op,
    output logic [CNT_W-1:0] o_instr_count
);

`ifdef CALC_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_EXEC   = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [3:0] WAIT_LOAD = 4'(ALU_LATENCY - 1);

    logic [1:0]       r_state;
    logic [3:0]       r_wait;
    logic [4:0]       r_alu_opcode;
    logic [12:0]      r_reg_a;
    logic [12:0]      r_reg_b;
    logic             r_sel_b_mem;
    logic             r_sel_a_c;
    logic             r_sel_c_mem;
    logic             r_is_mem;
    logic             r_illegal;
    logic             r_mem_write;
    logic             r_done;
    logic             r_illegal_op;
    logic [CNT_W-1:0] r_count;

    logic [4:0] w_opcode;
    logic       w_sel_b_mem;
    logic       w_sel_a_c;
    logic       w_sel_c_mem;
    logic       w_is_mem;
    logic       w_illegal;
    logic       w_unused;

    assign w_opcode = i_instruction[31:27];
    assign w_unused = i_instruction[0];

    always_comb begin
        w_sel_b_mem = 1'b0;
        w_sel_a_c   = 1'b0;
        w_sel_c_mem = 1'b0;
        w_is_mem    = 1'b0;
        w_illegal   = 1'b0;
        case (w_opcode)
            5'b10001, 5'b10010: begin
                w_sel_b_mem = 1'b1;
                w_is_mem    = 1'b1;
            end
            5'b10100: begin
                w_sel_a_c = 1'b1;
                w_is_mem  = 1'b1;
            end
            5'b11000: begin
                w_sel_c_mem = 1'b1;
                w_is_mem    = 1'b1;
            end
            // Any other opcode with bit 4 set is illegal; bit 4 clear is a plain ALU op.
            default: w_illegal = w_opcode[4];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_wait       <= '0;
            r_alu_opcode <= '0;
            r_reg_a      <= '0;
            r_reg_b      <= '0;
            r_sel_b_mem  <= 1'b0;
            r_sel_a_c    <= 1'b0;
            r_sel_c_mem  <= 1'b0;
            r_is_mem     <= 1'b0;
            r_illegal    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_done       <= 1'b0;
            r_illegal_op <= 1'b0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_instr_valid) begin
                        r_alu_opcode <= w_opcode;
                        r_reg_a      <= i_instruction[26:14];
                        r_reg_b      <= i_instruction[13:1];
                        r_sel_b_mem  <= w_sel_b_mem;
                        r_sel_a_c    <= w_sel_a_c;
                        r_sel_c_mem  <= w_sel_c_mem;
                        r_is_mem     <= w_is_mem;
                        r_illegal    <= w_illegal;
                        r_state      <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_wait <= WAIT_LOAD;
                    if (TRAP_EN && r_illegal) begin
                        // Trapped opcodes skip EXEC entirely.
                        r_done       <= 1'b1;
                        r_illegal_op <= 1'b1;
                        r_count      <= r_count + CNT_W'(1);
                        r_state      <= S_WB;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_wait == 4'd0) begin
                        // Pulses are registered on WB entry so they line up with WB.
                        r_done      <= 1'b1;
                        r_mem_write <= r_is_mem;
                        r_count     <= r_count + CNT_W'(1);
                        r_state     <= S_WB;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                default: begin
                    r_done       <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_illegal_op <= 1'b0;
                    r_alu_opcode <= '0;
                    r_reg_a      <= '0;
                    r_reg_b      <= '0;
                    r_sel_b_mem  <= 1'b0;
                    r_sel_a_c    <= 1'b0;
                    r_sel_c_mem  <= 1'b0;
                    r_is_mem     <= 1'b0;
                    r_illegal    <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign o_instr_ready       = (r_state == S_IDLE);
    assign o_alu_opcode        = r_alu_opcode;
    assign o_reg_a             = r_reg_a;
    assign o_reg_b             = r_reg_b;
    assign o_reg_b_mem_mux     = r_sel_b_mem;
    assign o_reg_a_reg_c_mux   = r_sel_a_c;
    assign o_reg_c_mem_out_mux = r_sel_c_mem;
    assign o_mem_write         = r_mem_write;
    assign o_done              = r_done;
    assign o_illegal_op        = r_illegal_op;
    assign o_instr_count       = r_count;

endmodule
